polyvec_unpack_scheduler: RTL and testbench
===========================================

// Module: polyvec_unpack_scheduler
// PURPOSE
//  Sequences the masked secret-key unpack unit (poly_frombytes + mask) for one full polyvec.
//  Launches the unit, counts its 128-bit chunk strobes and writes each share pair (s1/s2)
//  to the share RAMs with generated addresses. Supervises the run with a per-chunk timeout
//  and an abort path. Sits between the decaps top-level FSM and the share memories.
// PARAMETERS
//  KYBER_K    2    polynomials per polyvec
//  KYBER_N    256  coefficients per polynomial
//  CHUNK_SZ   128  bits per share chunk (8 x 16-bit coefficients)
//  NCHUNK     KYBER_K*KYBER_N/8 = 64  chunks per run
//  ADDR_W     6    share-RAM address width, >= clog2(NCHUNK)
//  TIMEOUT    1023 max cycles allowed between chunk strobes
// PORTS
//  clk          in   1         clock
//  resetn       in   1         async active-low reset
//  start_i      in   1         request one polyvec unpack; sampled in IDLE only
//  abort_i      in   1         cancel current run; ignored in IDLE/DONE
//  busy_o       out  1         high from accepted start until return to IDLE
//  done_o       out  1         1-cycle pulse: run complete, all NCHUNK writes issued
//  err_o        out  1         sticky; set on timeout, abort or chunk-count mismatch; cleared by next start
//  u_enable_o   out  1         launch pulse to unpack unit (exactly 1 cycle per run)
//  u_out_ready_i in  1         unit chunk-valid level
//  u_done_i     in   1         unit Function_Done
//  u_s1_i       in   CHUNK_SZ  unit share 1 (random mask)
//  u_s2_i       in   CHUNK_SZ  unit share 2 (masked value)
//  prng_en_o    out  1         PRNG run enable; high while unit active
//  mem_we_o     out  1         share-RAM write strobe
//  mem_addr_o   out  ADDR_W    chunk address 0..NCHUNK-1
//  mem_poly_o   out  1         polynomial index = chunk_cnt / (KYBER_N/8)
//  mem_s1_o     out  CHUNK_SZ  share 1 write data
//  mem_s2_o     out  CHUNK_SZ  share 2 write data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; chunk_cnt=0, tmo_cnt=0, rdy_q=0.
//  Clocking: all outputs registered.
//  Chunk strobe: chunk_evt = u_out_ready_i & ~rdy_q. Unit holds out_ready across idle cycles,
//   so only rising edges are counted.
//  FSM:
//   IDLE   -start_i-> LAUNCH; clear err_o, chunk_cnt, tmo_cnt; busy_o=1.
//   LAUNCH  u_enable_o=1 for this cycle only; prng_en_o=1; -> COLLECT.
//   COLLECT on chunk_evt:
//    - next cycle: mem_we_o=1, mem_addr_o=chunk_cnt, data = u_s1_i/u_s2_i captured at the event.
//    - chunk_cnt++, tmo_cnt=0.
//    u_done_i on the same cycle as chunk_evt (final chunk) -> DONE; write still issued.
//    If chunk_cnt+1 != NCHUNK at u_done_i -> err_o=1, DONE.
//    tmo_cnt==TIMEOUT -> err_o=1, ERR.
//    abort_i -> DRAIN.
//   DRAIN   writes suppressed; wait u_done_i -> ERR (err_o=1); timeout also -> ERR.
//   DONE    done_o pulse 1 cycle; prng_en_o=0 -> IDLE.
//   ERR     done_o pulse 1 cycle with err_o=1; prng_en_o=0 -> IDLE.
//  Boundaries:
//   - start_i while busy: ignored.
//   - Extra chunk_evt beyond NCHUNK-1: no write (address never wraps); err_o=1.
//   - abort_i and u_done_i in the same cycle: abort wins; run reported as error.
//   - Reset mid-run: immediate IDLE, mem_we_o drops asynchronously. The unit also resets,
//     so no drain is needed.
//  Latency: start_i -> u_enable_o is 1 cycle; chunk_evt -> mem_we_o is 1 cycle;
//   final u_done_i -> done_o is 2 cycles.
// STRUCTURE
//  kyber_pkg: KYBER_K, KYBER_N, CHUNK_SZ, NCHUNK, FSM state localparams
//   (IDLE, LAUNCH, COLLECT, DRAIN, DONE, ERR; 3-bit encoding).
//  Sub-module: unpack_sched_timeout (loadable saturating counter, clear/enable, expired flag).
//  Edge detect, chunk counter and write-register stage are inline.
// TESTING
//  1 Nominal: start; model unit emits 64 edges then done with final edge
//    -> 64 writes, addr 0..63, poly 0 for addr<32 and 1 for addr>=32, done_o at +2, err_o=0.
//  2 Level hold: out_ready held high 5 cycles per chunk -> exactly one write per chunk.
//  3 Timeout: model stalls after chunk 10 for 1024 cycles
//    -> ERR, err_o=1, done_o pulse, 10 writes only.
//  4 Abort at chunk 20: abort_i 1 cycle -> no writes after addr 19, waits u_done_i,
//    done_o with err_o=1.
//  5 Short run: u_done_i after 63 chunks -> err_o=1; restart clears err_o, full run passes.
//  6 Reset at chunk 30: resetn low 2 cycles -> all outputs 0; next start writes from addr 0.

Source files
------------

// File: rtl/polyvec_unpack_scheduler_pkg.sv
// polyvec_unpack_scheduler_pkg: sizing constants and FSM states for the polyvec unpack scheduler
package polyvec_unpack_scheduler_pkg;
    localparam int KYBER_K        = 2;
    localparam int KYBER_N        = 256;
    localparam int CHUNK_SZ       = 128;
    localparam int NCHUNK         = KYBER_K * KYBER_N / 8;
    localparam int CHUNK_PER_POLY = KYBER_N / 8;
    localparam int ADDR_W         = 6;
    localparam int TIMEOUT        = 1023;
    localparam int TMO_W          = $clog2(TIMEOUT + 1);
    localparam int CNT_W          = $clog2(NCHUNK + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_COLLECT,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/polyvec_unpack_scheduler_timeout.sv
// polyvec_unpack_scheduler_timeout: saturating idle-cycle counter with clear/enable and expiry flag
module polyvec_unpack_scheduler_timeout #(
    parameter int W     = 10,
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != W'(LIMIT))
            cnt <= cnt + 1'b1;
    end

    assign expired = cnt == W'(LIMIT);
endmodule

// File: rtl/polyvec_unpack_scheduler.sv
// polyvec_unpack_scheduler: launches the masked unpack unit, counts chunk strobes and writes
// each share pair to the share RAMs, with per-chunk timeout and abort supervision
module polyvec_unpack_scheduler
    import polyvec_unpack_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                u_enable_o,
    input  logic                u_out_ready_i,
    input  logic                u_done_i,
    input  logic [CHUNK_SZ-1:0] u_s1_i,
    input  logic [CHUNK_SZ-1:0] u_s2_i,
    output logic                prng_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_poly_o,
    output logic [CHUNK_SZ-1:0] mem_s1_o,
    output logic [CHUNK_SZ-1:0] mem_s2_o
);
    state_t           state;
    logic             rdy_q, chunk_evt, in_range, tmo_expired, tmo_clr, tmo_en;
    logic [CNT_W-1:0] chunk_cnt, final_cnt;

    // the unit holds out_ready high between chunks, so only rising edges count
    assign chunk_evt = u_out_ready_i & ~rdy_q;
    assign in_range  = chunk_cnt < CNT_W'(NCHUNK);
    assign final_cnt = chunk_cnt + CNT_W'(chunk_evt & in_range);
    assign tmo_clr   = chunk_evt | (state == S_IDLE) | (state == S_LAUNCH);
    assign tmo_en    = (state == S_COLLECT) | (state == S_DRAIN);

    polyvec_unpack_scheduler_timeout #(.W(TMO_W), .LIMIT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            rdy_q      <= 1'b0;
            chunk_cnt  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            u_enable_o <= 1'b0;
            prng_en_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_poly_o <= 1'b0;
            mem_s1_o   <= '0;
            mem_s2_o   <= '0;
        end else begin
            rdy_q      <= u_out_ready_i;
            u_enable_o <= 1'b0;
            done_o     <= 1'b0;
            mem_we_o   <= 1'b0;
            case (state)
                S_IDLE: if (start_i) begin
                    state      <= S_LAUNCH;
                    busy_o     <= 1'b1;
                    err_o      <= 1'b0;
                    chunk_cnt  <= '0;
                    u_enable_o <= 1'b1;
                    prng_en_o  <= 1'b1;
                end
                S_LAUNCH: state <= S_COLLECT;
                S_COLLECT: if (abort_i) begin
                    // abort beats a coincident done; the unit still has to finish if it has not
                    err_o     <= 1'b1;
                    state     <= u_done_i ? S_ERR : S_DRAIN;
                    prng_en_o <= ~u_done_i;
                end else begin
                    if (chunk_evt && in_range) begin
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= chunk_cnt[ADDR_W-1:0];
                        mem_poly_o <= chunk_cnt >= CNT_W'(CHUNK_PER_POLY);
                        mem_s1_o   <= u_s1_i;
                        mem_s2_o   <= u_s2_i;
                        chunk_cnt  <= chunk_cnt + 1'b1;
                    end else if (chunk_evt) begin
                        err_o <= 1'b1;
                    end
                    if (u_done_i) begin
                        state     <= S_DONE;
                        prng_en_o <= 1'b0;
                        if (final_cnt != CNT_W'(NCHUNK))
                            err_o <= 1'b1;
                    end else if (tmo_expired && !chunk_evt) begin
                        state     <= S_ERR;
                        err_o     <= 1'b1;
                        prng_en_o <= 1'b0;
                    end
                end
                S_DRAIN: if (u_done_i || tmo_expired) begin
                    state     <= S_ERR;
                    err_o     <= 1'b1;
                    prng_en_o <= 1'b0;
                end
                S_DONE, S_ERR: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polyvec_unpack_scheduler.sv
// tb_polyvec_unpack_scheduler: random-data unit model with write scoreboard for the unpack scheduler
module tb_polyvec_unpack_scheduler;
    import polyvec_unpack_scheduler_pkg::*;

    logic clk = 1'b0, resetn = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic u_out_ready_i = 1'b0, u_done_i = 1'b0;
    logic [CHUNK_SZ-1:0] u_s1_i = '0, u_s2_i = '0;
    logic busy_o, done_o, err_o, u_enable_o, prng_en_o, mem_we_o, mem_poly_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [CHUNK_SZ-1:0] mem_s1_o, mem_s2_o;

    typedef logic [ADDR_W+2*CHUNK_SZ:0] wr_t;
    wr_t exp_q[$];
    wr_t act_q[$];
    int n_tests = 0, n_fail = 0, cyc = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0, drv_done_cyc = 0;
    logic done_err = 1'b0;

    polyvec_unpack_scheduler dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .u_enable_o(u_enable_o),
        .u_out_ready_i(u_out_ready_i), .u_done_i(u_done_i), .u_s1_i(u_s1_i), .u_s2_i(u_s2_i),
        .prng_en_o(prng_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_poly_o(mem_poly_o), .mem_s1_o(mem_s1_o), .mem_s2_o(mem_s2_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // passive monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mem_we_o) act_q.push_back({mem_addr_o, mem_poly_o, mem_s1_o, mem_s2_o});
        if (u_enable_o) en_cnt++;
        if (done_o) begin
            done_cnt++;
            done_err = err_o;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [299:0] act, input logic [299:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CHUNK_SZ-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // one chunk from the unit: out_ready rises with fresh shares, held for `hold` cycles
    task automatic emit(input int i, input int hold, input bit last);
        logic [CHUNK_SZ-1:0] s1, s2;
        s1 = rnd128();
        s2 = rnd128();
        u_s1_i = s1;
        u_s2_i = s2;
        u_out_ready_i = 1'b1;
        u_done_i = last;
        if (i < NCHUNK) exp_q.push_back({ADDR_W'(i), 1'(i / (KYBER_N / 8)), s1, s2});
        if (last) drv_done_cyc = cyc;
        tick();
        u_done_i = 1'b0;
        for (int h = 1; h < hold; h++) begin
            u_s1_i = rnd128();
            u_s2_i = rnd128();
            tick();
        end
        u_out_ready_i = 1'b0;
        u_s1_i = rnd128();
        u_s2_i = rnd128();
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic launch();
        int t;
        t = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (!u_enable_o && t < 8) begin
            tick();
            t++;
        end
        check("enable_latency", t, 0);
        check("busy_on", busy_o, 1);
        check("err_clr", err_o, 0);
        tick();
        tick();
        check("prng_on", prng_en_o, 1);
    endtask

    task automatic run(input string nm, input int nch, input int hold, input int stall_at,
                       input int abort_at, input bit exp_err);
        int base, en0, d0, t;
        bit nominal;
        base = act_q.size();
        en0 = en_cnt;
        d0 = done_cnt;
        t = 0;
        nominal = 1'b1;
        exp_q.delete();
        launch();
        for (int i = 0; i < nch; i++) begin
            if (i == stall_at) begin
                nominal = 1'b0;
                break;
            end
            if (i == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                repeat (3) tick();
                u_done_i = 1'b1;
                tick();
                u_done_i = 1'b0;
                nominal = 1'b0;
                break;
            end
            if (i == 5) start_i = 1'b1;
            emit(i, hold, i == nch - 1);
            start_i = 1'b0;
        end
        while (done_cnt == d0 && t < 3000) begin
            tick();
            t++;
        end
        check({nm, "_done"}, done_cnt - d0, 1);
        check({nm, "_err"}, done_err, exp_err);
        if (nominal) check({nm, "_latency"}, done_cyc - drv_done_cyc, 2);
        tick();
        check({nm, "_idle"}, {busy_o, prng_en_o, done_o}, 0);
        check({nm, "_launches"}, en_cnt - en0, 1);
        check({nm, "_nwr"}, act_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++)
            check({nm, "_wr"}, act_q[base + k], exp_q[k]);
    endtask

    task automatic reset_mid(input int at);
        exp_q.delete();
        launch();
        for (int i = 0; i < at; i++) emit(i, 1, 1'b0);
        u_out_ready_i = 1'b1;
        tick();
        check("rst_pre_we", mem_we_o, 1);
        #2 resetn = 1'b0;
        #1 check("rst_async_we", mem_we_o, 0);
        u_out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {busy_o, done_o, err_o, u_enable_o, prng_en_o, mem_we_o,
                              mem_addr_o, mem_poly_o, mem_s1_o, mem_s2_o}, 0);
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy_o, done_o, err_o, u_enable_o, prng_en_o, mem_we_o,
                                mem_addr_o, mem_poly_o, mem_s1_o, mem_s2_o}, 0);
        resetn = 1'b1;
        tick();
        tick();
        run("nominal", 64, 1, -1, -1, 1'b0);
        run("hold5", 64, 5, -1, -1, 1'b0);
        run("timeout", 64, 1, 10, -1, 1'b1);
        run("abort", 64, 1, -1, 20, 1'b1);
        run("short", 63, 1, -1, -1, 1'b1);
        run("restart", 64, 1, -1, -1, 1'b0);
        run("extra", 65, 1, -1, -1, 1'b1);
        reset_mid(30);
        run("post_reset", 64, 2, -1, -1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
